// File: rtl/next_pc_predict.sv
// Fetch-PC generator: holds the fetch PC and selects redirect, stall hold, BTB
// prediction or PC+4; the direct-mapped BTB is trained by resolved branches.
module next_pc_predict #(
    parameter int unsigned   AW          = 32,
    parameter logic [AW-1:0] RESET_PC    = '0,
    parameter int unsigned   BTB_ENTRIES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [AW-1:0] redirect_pc_i,
    input  logic          upd_valid_i,
    input  logic [AW-1:0] upd_pc_i,
    input  logic          upd_taken_i,
    input  logic [AW-1:0] upd_target_i,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] pc4_o,
    output logic          pred_taken_o,
    output logic [AW-1:0] pred_target_o
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = AW - IDX_W - 2;
    localparam int unsigned TGT_W = AW - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [AW-1:0]          pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];
    logic [1:0]             ctr_d [BTB_ENTRIES];
    logic [TGT_W-1:0]       tgt_q [BTB_ENTRIES];
    logic [TGT_W-1:0]       tgt_d [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;
    logic             pred_taken;
    logic [AW-1:0]    pred_target;
    logic             unused_low_bits;

    assign lk_idx  = pc_q[IDX_W+1:2];
    assign lk_tag  = pc_q[AW-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[AW-1:IDX_W+2];

    // Byte-offset bits of incoming addresses carry no information for word fetch.
    assign unused_low_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    // Valid gates the unreset tag/counter/target arrays so outputs never go X.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        lk_hit      = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
            lk_hit = 1'b1;
        end
        if (lk_hit && ctr_q[lk_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = {tgt_q[lk_idx], 2'b00};
        end
    end

    always_comb begin
        pc_d = pc_q + AW'(4);
        if (redirect_i) begin
            pc_d = {redirect_pc_i[AW-1:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        tgt_d   = tgt_q;
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    ctr_d[upd_idx] = sat_inc(ctr_q[upd_idx]);
                    tgt_d[upd_idx] = upd_target_i[AW-1:2];
                end else begin
                    ctr_d[upd_idx] = sat_dec(ctr_q[upd_idx]);
                end
            end else if (upd_taken_i) begin
                // Allocate weakly taken so a single taken branch starts predicting.
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                ctr_d[upd_idx]   = 2'b10;
                tgt_d[upd_idx]   = upd_target_i[AW-1:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: BTB payload arrays are deliberately unreset; clearing valid_q is enough.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        ctr_q <= ctr_d;
        tgt_q <= tgt_d;
    end

    assign pc_o          = pc_q;
    assign pc4_o         = pc_q + AW'(4);
    assign pred_taken_o  = pred_taken;
    assign pred_target_o = pred_target;

endmodule

// File: tb/tb_next_pc_predict.sv
// Scoreboard bench for next_pc_predict: expectations are queued when stimulus is
// driven and compared one cycle later on the falling edge.
module tb_next_pc_predict;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_i, upd_valid_i, upd_taken_i;
    logic [31:0] redirect_pc_i, upd_pc_i, upd_target_i;
    logic [31:0] pc_a, pc4_a, ptg_a, pc_b, pc4_b, ptg_b;
    logic        pt_a, pt_b;

    always #5 clk = ~clk;

    next_pc_predict dut_a (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .pc_o(pc_a), .pc4_o(pc4_a), .pred_taken_o(pt_a), .pred_target_o(ptg_a)
    );

    next_pc_predict #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .pc_o(pc_b), .pc4_o(pc4_b), .pred_taken_o(pt_b), .pred_target_o(ptg_b)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tg;
    } exp_t;

    typedef struct packed {
        logic        rd;
        logic [31:0] rpc;
        logic        st;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_tg;
    } row_t;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t exp;

    task automatic idle_inputs();
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        tests++; if (pc_a !== 32'h0) begin fails++; $display("FAIL reset_pc_a got %h exp %h", pc_a, 32'h0); end
        tests++; if (pc_b !== 32'hFFFF_FFF8) begin fails++; $display("FAIL reset_pc_b got %h exp %h", pc_b, 32'hFFFF_FFF8); end
        tests++; if ({pt_a, ptg_a} !== 33'h0) begin fails++; $display("FAIL reset_pred got %b/%h exp 0/0", pt_a, ptg_a); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{32'h0, 1'b0, 32'h0});
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            tests++; if (pc_a !== exp.pc) begin fails++; $display("FAIL free_run[%0d] pc got %h exp %h", i, pc_a, exp.pc); end
            tests++; if (pt_a !== 1'b0) begin fails++; $display("FAIL free_run[%0d] pred got %b exp 0", i, pt_a); end
            if (i < 3) begin
                exp_q.push_back('{exp.pc + 32'h4, 1'b0, 32'h0});
                @(negedge clk);
            end
        end
    endtask

    task automatic test_stall();
        redirect_i = 1'b1; redirect_pc_i = 32'h8;
        exp_q.push_back('{32'h8, 1'b0, 32'h0});
        @(negedge clk);
        idle_inputs();
        exp = exp_q.pop_front();
        tests++; if (pc_a !== exp.pc) begin fails++; $display("FAIL stall_setup pc got %h exp %h", pc_a, exp.pc); end
        for (int i = 0; i < 4; i++) begin
            stall_i = (i < 3);
            exp_q.push_back('{(i < 3) ? 32'h8 : 32'hC, 1'b0, 32'h0});
            @(negedge clk);
            exp = exp_q.pop_front();
            tests++; if (pc_a !== exp.pc) begin fails++; $display("FAIL stall[%0d] pc got %h exp %h", i, pc_a, exp.pc); end
        end
        idle_inputs();
    endtask

    task automatic test_stall_redirect();
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        exp_q.push_back('{32'h0000_0100, 1'b0, 32'h0});
        tests++; if (pc_a !== 32'hC) begin fails++; $display("FAIL redirect_early pc got %h exp %h", pc_a, 32'hC); end
        @(negedge clk);
        idle_inputs();
        exp = exp_q.pop_front();
        tests++; if (pc_a !== exp.pc) begin fails++; $display("FAIL stall_redirect pc got %h exp %h", pc_a, exp.pc); end
        tests++; if (pc4_a !== exp.pc + 32'h4) begin fails++; $display("FAIL stall_redirect pc4 got %h exp %h", pc4_a, exp.pc + 32'h4); end
    endtask

    // Training, hysteresis, aliasing, saturation and same-cycle update/lookup.
    task automatic test_btb();
        row_t rows[21];
        rows = '{
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b1, 32'h80,  32'h100, 1'b0, 32'h0},
            '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  1'b1, 32'h80},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h80,  1'b0, 32'h0},
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0, 32'h0,   32'h80,  1'b0, 32'h0},
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0, 32'h0,   32'h80,  1'b0, 32'h0},
            '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  1'b0, 32'h0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h44,  1'b0, 32'h0},
            '{1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80,  32'h40,  1'b0, 32'h0},
            '{1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80,  32'h40,  1'b1, 32'h80},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h80,  1'b0, 32'h0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h84,  1'b0, 32'h0},
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b1, 32'h203, 32'h84,  1'b0, 32'h0},
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b1, 32'h203, 32'h84,  1'b0, 32'h0},
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b1, 32'h203, 32'h84,  1'b0, 32'h0},
            '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  1'b1, 32'h200},
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0, 32'h0,   32'h40,  1'b1, 32'h200},
            '{1'b0, 32'h0,  1'b1, 1'b1, 32'h80, 1'b0, 32'h0,   32'h40,  1'b1, 32'h200},
            '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h80,  1'b0, 32'h0},
            '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  1'b1, 32'h200},
            '{1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 1'b0, 32'h0,   32'h200, 1'b0, 32'h0},
            '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  1'b0, 32'h0}
        };
        foreach (rows[i]) begin
            redirect_i = rows[i].rd; redirect_pc_i = rows[i].rpc; stall_i = rows[i].st;
            upd_valid_i = rows[i].uv; upd_pc_i = rows[i].upc;
            upd_taken_i = rows[i].ut; upd_target_i = rows[i].utg;
            exp_q.push_back('{rows[i].e_pc, rows[i].e_pt, rows[i].e_tg});
            @(negedge clk);
            exp = exp_q.pop_front();
            tests++; if (pc_a !== exp.pc) begin fails++; $display("FAIL btb[%0d] pc got %h exp %h", i, pc_a, exp.pc); end
            tests++; if ({pt_a, ptg_a} !== {exp.pt, exp.tg}) begin
                fails++; $display("FAIL btb[%0d] pred got %b/%h exp %b/%h", i, pt_a, ptg_a, exp.pt, exp.tg);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midrun();
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h300;
        exp_q.push_back('{32'h40, 1'b1, 32'h300});
        @(negedge clk);
        idle_inputs();
        exp = exp_q.pop_front();
        tests++; if ({pt_a, ptg_a} !== {exp.pt, exp.tg}) begin fails++; $display("FAIL pre_reset pred got %b/%h exp %b/%h", pt_a, ptg_a, exp.pt, exp.tg); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (pc_a !== 32'h0) begin fails++; $display("FAIL async_reset pc_a got %h exp %h", pc_a, 32'h0); end
        tests++; if ({pt_a, ptg_a} !== 33'h0) begin fails++; $display("FAIL async_reset pred got %b/%h exp 0/0", pt_a, ptg_a); end
        tests++; if (pc_b !== 32'hFFFF_FFF8) begin fails++; $display("FAIL async_reset pc_b got %h exp %h", pc_b, 32'hFFFF_FFF8); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{32'hFFFF_FFFC, 1'b0, 32'h0});
        @(negedge clk);
        exp = exp_q.pop_front();
        tests++; if (pc_b !== exp.pc) begin fails++; $display("FAIL wrap0 pc_b got %h exp %h", pc_b, exp.pc); end
        tests++; if (pc4_b !== 32'h0) begin fails++; $display("FAIL wrap0 pc4_b got %h exp %h", pc4_b, 32'h0); end
        exp_q.push_back('{32'h0, 1'b0, 32'h0});
        @(negedge clk);
        exp = exp_q.pop_front();
        tests++; if (pc_b !== exp.pc) begin fails++; $display("FAIL wrap1 pc_b got %h exp %h", pc_b, exp.pc); end
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        exp_q.push_back('{32'h40, 1'b0, 32'h0});
        @(negedge clk);
        idle_inputs();
        exp = exp_q.pop_front();
        tests++; if ({pc_a, pt_a, ptg_a} !== {exp.pc, exp.pt, exp.tg}) begin
            fails++; $display("FAIL post_reset_btb got %h/%b/%h exp %h/%b/%h", pc_a, pt_a, ptg_a, exp.pc, exp.pt, exp.tg);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall();
        test_stall_redirect();
        test_btb();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
